bcd_addsub_seq: RTL
===================

BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits per operand (legal range 2..8).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b); latched with start.
REQ-007 The block SHALL have port a, input, 4*DIGITS bits: BCD minuend or addend, least significant digit in [3:0]; latched with start.
REQ-008 The block SHALL have port b, input, 4*DIGITS bits: BCD subtrahend or addend, same layout; latched with start.
REQ-009 The block SHALL have port busy, output, 1 bit: high in CALC and FIX.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse in DONE.
REQ-011 The block SHALL have port result, output, 4*DIGITS bits: BCD magnitude of the result.
REQ-012 The block SHALL have port cout, output, 1 bit: decimal carry out of an add; always 0 for subtract.
REQ-013 The block SHALL have port neg, output, 1 bit: 1 when a subtract result is negative; always 0 for add.
REQ-014 The block SHALL have port err, output, 1 bit: 1 when any latched operand digit exceeds 9.

Function
REQ-015 The block SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-016 In IDLE, start=1 SHALL do all of the following: latch op, a and b; clear the digit index to 0; clear result, cout, neg and err.
REQ-017 On an accepted start, the next state SHALL be DONE with err=1 and result=0 if any digit of a or b exceeds 9; otherwise the next state SHALL be CALC.
REQ-018 In CALC, the block SHALL process exactly one digit per cycle, least significant digit first, at index i = 0..DIGITS-1.
REQ-019 The digit step in CALC SHALL be: bd = b_i for add, or 9 - b_i for subtract; s = a_i + bd + c (5-bit); if s > 9, then s = s + 6 and c = 1, else c = 0; result_i = s[3:0].
REQ-020 The carry c SHALL initialise to 0 for add and to 1 for subtract.
REQ-021 After digit DIGITS-1, an add SHALL go to DONE with cout = c.
REQ-022 After digit DIGITS-1, a subtract with c=1 SHALL go to DONE with neg=0.
REQ-023 After digit DIGITS-1, a subtract with c=0 SHALL go to FIX with neg=1, index reset to 0 and c=1.
REQ-024 In FIX, the block SHALL replace result with its ten's complement, one digit per cycle, LSD first, using the CALC digit step with a_i = 9 - result_i, bd = 0 and initial c = 1; after digit DIGITS-1 it SHALL go to DONE, and the final carry SHALL be discarded.
REQ-025 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-026 Latency from the start-accept edge T SHALL be: done high in cycle T+DIGITS+1 for add and non-negative subtract; T+2*DIGITS+1 for negative subtract; T+1 for err.
REQ-027 start SHALL be ignored while the block is not in IDLE, including in DONE; changes to a, b or op after acceptance SHALL have no effect.
REQ-028 result, cout, neg and err SHALL hold their values from DONE until the next accepted start.
REQ-029 A subtract with a = b SHALL yield result 0 and neg 0.
REQ-030 Results SHALL wrap modulo 10^DIGITS, with overflow reported only via cout.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL enter IDLE, set the index and c to 0, and force busy, done, cout, neg, err and result to 0.
REQ-032 Reset SHALL override start in the same cycle.
REQ-033 Reset asserted mid-CALC or mid-FIX SHALL abort the operation with no done pulse.

Verification (DIGITS=4, start accepted at edge T)
REQ-034 add 1234 + 5678 -> result 6912, cout 0, neg 0, done at T+5, busy high T+1..T+4.
REQ-035 add 9999 + 0001 -> result 0000, cout 1, done at T+5.
REQ-036 sub 5000 - 1234 -> result 3766, neg 0, cout 0, done at T+5.
REQ-037 sub 0123 - 0456 -> result 0333, neg 1, done at T+9, busy high T+1..T+8.
REQ-038 a = 0x00A0, op=0 -> err 1, result 0000, done at T+1, busy never high.
REQ-039 Both of the following SHALL be covered: (a) a second start at T+2 with different operands -> ignored, first result unchanged; (b) rst at T+2 of a subtract -> no done pulse, all outputs 0, and a following start operates normally.

Source files
------------

// File: rtl/bcd_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_addsub_seq
// Function : Digit-serial BCD adder/subtractor (LSD first) producing a BCD
//            magnitude plus carry/negative/error flags.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  cout,
    output logic                  neg,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] c_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_a, r_b, r_result;
    logic            r_op, r_c, r_cout, r_neg, r_err;
    logic [IW-1:0]   r_idx;
    logic [3:0]      w_da, w_db, w_digit;
    logic [4:0]      w_raw;
    logic            w_carry, w_last, w_bad;

    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) w_bad = 1'b1;
        end
    end

    // Shared decimal digit step; FIX reuses it to form 9's complement + 1.
    always_comb begin
        w_da = r_a[3:0];
        w_db = r_op ? (4'd9 - r_b[3:0]) : r_b[3:0];
        if (r_state == S_FIX) begin
            w_da = 4'd9 - r_result[3:0];
            w_db = 4'd0;
        end
        w_raw   = {1'b0, w_da} + {1'b0, w_db} + {4'd0, r_c};
        w_carry = (w_raw > 5'd9);
        w_digit = w_carry ? (w_raw[3:0] + 4'd6) : w_raw[3:0];
    end

    assign w_last = (r_idx == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = w_bad ? S_DONE : S_CALC;
            S_CALC: begin
                busy = 1'b1;
                if (w_last) w_next = (r_op && !w_carry) ? S_FIX : S_DONE;
            end
            S_FIX: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operands shift right one digit per step; result digits enter at the top,
    // so after DIGITS steps every digit sits in its own position again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_c      <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a      <= a;
                    r_b      <= b;
                    r_op     <= op;
                    r_idx    <= '0;
                    r_c      <= op;
                    r_result <= '0;
                    r_cout   <= 1'b0;
                    r_neg    <= 1'b0;
                    r_err    <= w_bad;
                end
                S_CALC: begin
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_result <= {w_digit, r_result[W-1:4]};
                    r_c      <= w_carry;
                    r_idx    <= r_idx + IW'(1);
                    if (w_last) begin
                        r_idx <= '0;
                        if (!r_op) begin
                            r_cout <= w_carry;
                        end else if (!w_carry) begin
                            r_neg <= 1'b1;
                            r_c   <= 1'b1;
                        end
                    end
                end
                S_FIX: begin
                    r_result <= {w_digit, r_result[W-1:4]};
                    r_c      <= w_carry;
                    r_idx    <= w_last ? '0 : (r_idx + IW'(1));
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign neg    = r_neg;
    assign err    = r_err;

endmodule
`default_nettype wire
